// File: rtl/feedback_writer.sv
// feedback_writer: producer side of the per-channel FM feedback path.
// Averages the current and previous modulator output of a channel and
// writes the result into the channel feedback store. After reset it
// sweeps every channel to zero. A key-on clear zeroes a single channel.
module feedback_writer #(
  parameter int W   = 10,
  parameter int NCH = 9
) (
  input  logic                clk,
  input  logic                reset,      // synchronous, active-low
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_ch,
  input  logic                in_mod,
  input  logic signed [W-1:0] in_data,
  input  logic                clr_valid,
  input  logic [3:0]          clr_ch,
  output logic                wr,
  output logic [3:0]          waddr,
  output logic signed [W-1:0] wdata,
  output logic                busy
);

  localparam int            CW       = 4;
  localparam logic [CW-1:0] NCH_C    = CW'(NCH);
  localparam logic [CW-1:0] LAST_CH  = CW'(NCH - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [CW-1:0]       waddr_q, waddr_d;
  logic signed [W-1:0] wdata_q, wdata_d;

  // Last modulator output per channel.
  logic signed [W-1:0] prev_q [NCH];

  // Single write port into the prev array, driven by the next-state logic.
  logic                prev_we;
  logic [CW-1:0]       prev_wa;
  logic signed [W-1:0] prev_wd;

  logic                ch_ok;
  logic                clr_hit;
  logic                smp_hit;
  logic [CW-1:0]       rd_idx;
  logic signed [W-1:0] prev_rd;
  logic signed [W:0]   sum;
  logic signed [W-1:0] avg;

  assign in_ready = (state_q == S_RUN);
  assign busy     = (state_q == S_INIT);
  assign wr       = wr_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;

  // Decode acceptance of clears and samples, and form the floored average.
  always_comb begin
    ch_ok   = (in_ch < NCH_C);
    clr_hit = in_ready && clr_valid && (clr_ch < NCH_C);
    // A valid clear owns the write port; any sample that cycle is dropped.
    smp_hit = in_valid && in_ready && in_mod && ch_ok && !clr_hit;
    rd_idx  = ch_ok ? in_ch : '0;
    prev_rd = prev_q[rd_idx];
    // Sign-extend both operands so the sum cannot overflow.
    sum     = {prev_rd[W-1], prev_rd} + {in_data[W-1], in_data};
    avg     = sum[W:1];
  end

  // Next-state, write-port and output-register logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    prev_we = 1'b0;
    prev_wa = '0;
    prev_wd = '0;
    case (state_q)
      S_INIT: begin
        prev_we = 1'b1;
        prev_wa = cnt_q;
        wr_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = '0;
        if (cnt_q == LAST_CH) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN: begin
        if (clr_hit) begin
          prev_we = 1'b1;
          prev_wa = clr_ch;
          wr_d    = 1'b1;
          waddr_d = clr_ch;
          wdata_d = '0;
        end else if (smp_hit) begin
          prev_we = 1'b1;
          prev_wa = in_ch;
          prev_wd = in_data;
          wr_d    = 1'b1;
          waddr_d = in_ch;
          wdata_d = avg;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Per-channel prev storage.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; the init sweep zeroes it, so it can map to plain storage.
    if (reset && prev_we) begin
      prev_q[prev_wa] <= prev_wd;
    end
  end

endmodule
